ws2812_led_driver: RTL and testbench



---
 rtl/led_pkg.sv | 26 ++
 rtl/ws2812_led_driver_if.sv | 13 +
 rtl/led_bit_timer.sv | 30 +++
 rtl/ws2812_led_driver.sv | 128 ++++++++++++
 tb/tb_ws2812_led_driver.sv | 136 +++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared states, word size and default timing for the WS2812 driver
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } led_state_e;

  localparam int WORD_BITS   = 24;
  localparam int T0H_DEFAULT = 19;
  localparam int T1H_DEFAULT = 38;
  localparam int BIT_DEFAULT = 60;
  localparam int RST_DEFAULT = 14400;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ws2812_led_driver_if.sv
// rtl/ws2812_led_driver_if.sv - colour load request and serial line bundle
interface ws2812_led_driver_if;
  import led_pkg::*;

  logic [WORD_BITS-1:0] rgb;
  logic                 load;
  logic                 to_light;
  logic                 done;

  modport master (output rgb, output load, input to_light, input done);
  modport slave  (input rgb, input load, output to_light, output done);

endinterface

// File: rtl/led_bit_timer.sv
// rtl/led_bit_timer.sv - loadable down-counter; tc flags the final cycle of a timed phase
module led_bit_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/ws2812_led_driver.sv
// rtl/ws2812_led_driver.sv - serialises 24-bit colour words as WS2812 pulse-width bits
module ws2812_led_driver
  import led_pkg::*;
#(
  parameter int T0H_CYC = T0H_DEFAULT,
  parameter int T1H_CYC = T1H_DEFAULT,
  parameter int BIT_CYC = BIT_DEFAULT,
  parameter int RST_CYC = RST_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  ws2812_led_driver_if.slave  led
);

  localparam int MAXP = max4(T0H_CYC, T1H_CYC, BIT_CYC, RST_CYC);
  localparam int CW   = ($clog2(MAXP) > 0) ? $clog2(MAXP) : 1;

  led_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic                 word_end_q, word_end_d;
  logic                 to_light_q, to_light_d;
  logic                 done_q, done_d;

  logic                 tmr_load;
  logic [CW-1:0]        tmr_val;
  logic                 tmr_tc;

  // Timer is loaded with (length - 1) so tc marks the last cycle of each phase.
  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
  endfunction

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? CW'(BIT_CYC - T1H_CYC - 1) : CW'(BIT_CYC - T0H_CYC - 1);
  endfunction

  led_bit_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_end_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    unique case (state_q)
      IDLE: begin
        if (led.load) begin
          shreg_d   = led.rgb;
          bit_cnt_d = '0;
          tmr_load  = 1'b1;
          tmr_val   = high_len(led.rgb[WORD_BITS-1]);
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = low_len(shreg_q[WORD_BITS-1]);
          state_d  = LOW;
        end
      end
      LOW: begin
        if (tmr_tc) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == 5'(WORD_BITS - 1)) begin
            word_end_d = 1'b1;
            bit_cnt_d  = '0;
            tmr_load   = 1'b1;
            if (led.load) begin
              shreg_d = led.rgb;
              tmr_val = high_len(led.rgb[WORD_BITS-1]);
              state_d = HIGH;
            end else begin
              tmr_val = CW'(RST_CYC - 1);
              state_d = LATCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            tmr_load  = 1'b1;
            tmr_val   = high_len(shreg_q[WORD_BITS-2]);
            state_d   = HIGH;
          end
        end
      end
      LATCH: begin
        if (tmr_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs trail the state by one register so the pin is glitch-free.
  always_comb begin
    to_light_d = (state_q == HIGH);
    done_d     = word_end_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_end_q <= 1'b0;
      to_light_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_end_q <= word_end_d;
      to_light_q <= to_light_d;
      done_q     <= done_d;
    end
  end

  assign led.to_light = to_light_q;
  assign led.done     = done_q;

endmodule

// File: tb/tb_ws2812_led_driver.sv
// tb/tb_ws2812_led_driver.sv - random and directed stimulus against a timeline model of the LED line
module tb_ws2812_led_driver;

  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int BIT = 6;
  localparam int RST = 10;
  localparam int WB  = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ws2812_led_driver_if bus ();

  ws2812_led_driver #(
    .T0H_CYC (T0H),
    .T1H_CYC (T1H),
    .BIT_CYC (BIT),
    .RST_CYC (RST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .led (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  int          edge_n  = 0;
  bit          m_act   = 1'b0;
  int          m_start = 0;
  logic [23:0] m_word  = '0;
  int          m_free  = 0;
  int          m_done  = -1;
  logic        exp_tl, exp_done;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at edge %0d: got %0b expected %0b", tag, edge_n, got, exp);
    end
  endtask

  // Expected line level is read off the word timeline: start edge, bit index, position in bit.
  task automatic model_edge(input logic l, input logic [23:0] r, input logic rs);
    int off, k, j, hl;
    if (rs) begin
      exp_tl   = 1'b0;
      exp_done = 1'b0;
      m_act    = 1'b0;
      m_done   = -1;
      m_free   = edge_n + 1;
      return;
    end
    exp_done = (m_done == edge_n);
    exp_tl   = 1'b0;
    if (m_act && edge_n >= m_start + 1 && edge_n <= m_start + WB * BIT) begin
      off    = edge_n - m_start - 1;
      k      = off / BIT;
      j      = off % BIT;
      hl     = m_word[23 - k] ? T1H : T0H;
      exp_tl = (j < hl);
    end
    if (m_act && edge_n == m_start + WB * BIT) begin
      m_done = edge_n + 1;
      if (l) begin
        m_start = edge_n;
        m_word  = r;
      end else begin
        m_act  = 1'b0;
        m_free = edge_n + RST + 1;
      end
    end else if (!m_act && edge_n >= m_free && l) begin
      m_act   = 1'b1;
      m_start = edge_n;
      m_word  = r;
    end
  endtask

  task automatic step(input logic l, input logic [23:0] r, input logic rs);
    bus.load = l;
    bus.rgb  = r;
    rst      = rs;
    @(posedge clk);
    edge_n++;
    model_edge(l, r, rs);
    @(negedge clk);
    check_eq("to_light", bus.to_light, exp_tl);
    check_eq("done", bus.done, exp_done);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.rgb  = '0;
    @(negedge clk);

    // Reset, then idle with load low
    step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 24'h0, 1'b0);

    // Single word, load pulsed once, then latch and idle
    step(1'b1, 24'h00CEFF, 1'b0);
    for (int i = 0; i < 170; i++) step(1'b0, 24'h00CEFF, 1'b0);

    // Continuous load resends the same word back-to-back
    for (int i = 0; i < 3 * WB * BIT + 5; i++) step(1'b1, 24'h00CEFF, 1'b0);
    for (int i = 0; i < 170; i++) step(1'b0, 24'h0, 1'b0);

    // Chaining: load asserted exactly on the word-end cycle
    step(1'b1, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < WB * BIT - 1; i++) step(1'b0, 24'h123456, 1'b0);
    step(1'b1, 24'h000000, 1'b0);
    for (int i = 0; i < WB * BIT + RST + 10; i++) step(1'b0, 24'hABCDEF, 1'b0);

    // Mid-word reset at bit 10, then a fresh word; rgb churns during flight
    step(1'b1, 24'hA5C3F0, 1'b0);
    for (int i = 0; i < 10 * BIT + 2; i++) step(1'b0, 24'($urandom), 1'b0);
    step(1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0);
    step(1'b1, 24'h800001, 1'b0);
    for (int i = 0; i < WB * BIT + RST + 10; i++) step(1'b0, 24'($urandom), 1'b0);

    // Random loads, rgb churn and rare resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 40) == 0, 24'($urandom), ($urandom % 900) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
